// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access_pkg / mem_access
//
// MEM stage of a 5-stage MIPS pipeline. Issues loads and stores over a
// single-outstanding req/ack data bus and holds the pipeline stalled until the
// access completes. It then presents the load result, with byte and half loads
// sign-extended, to the MEM/WB register. Misaligned addresses raise AdEL or
// AdES, and a missing acknowledge raises a bus-error exception. Non-memory
// operations pass straight through combinationally.
//
// Ports
//   clk, rst            pipeline clock, synchronous active-high reset
//   aluop_i .. excepttype_i   EX/MEM register outputs
//   bus_rdata_i, bus_ack_i    data-bus response (ack is a one-cycle pulse)
//   wd_o, wreg_o, wdata_o     write-back controls and data to MEM/WB
//   excepttype_o, bad_addr_o  exception vector and faulting address
//   bus_req_o .. bus_wdata_o  data-bus request: word address, lanes, data
//   stallreq_o                stall request to the ctrl block
// -----------------------------------------------------------------------------
package mem_access_pkg;
  localparam int ALUOP_W   = 8;
  localparam int REG_W     = 32;
  localparam int REGADDR_W = 5;

  localparam logic [ALUOP_W-1:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [ALUOP_W-1:0] EXE_LB_OP   = 8'b1110_0000;
  localparam logic [ALUOP_W-1:0] EXE_LH_OP   = 8'b1110_0001;
  localparam logic [ALUOP_W-1:0] EXE_LW_OP   = 8'b1110_0011;
  localparam logic [ALUOP_W-1:0] EXE_LWPC_OP = 8'b1111_0011;
  localparam logic [ALUOP_W-1:0] EXE_SB_OP   = 8'b1110_1000;
  localparam logic [ALUOP_W-1:0] EXE_SH_OP   = 8'b1110_1001;
  localparam logic [ALUOP_W-1:0] EXE_SW_OP   = 8'b1110_1011;

  typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_t;
endpackage

module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ALUOP_W-1:0]   aluop_i,
  input  logic [REG_W-1:0]     mem_addr_i,
  input  logic [REG_W-1:0]     reg2_i,
  input  logic [REGADDR_W-1:0] wd_i,
  input  logic                 wreg_i,
  input  logic [REG_W-1:0]     wdata_i,
  input  logic [31:0]          excepttype_i,
  input  logic [31:0]          bus_rdata_i,
  input  logic                 bus_ack_i,
  output logic [REGADDR_W-1:0] wd_o,
  output logic                 wreg_o,
  output logic [REG_W-1:0]     wdata_o,
  output logic [31:0]          excepttype_o,
  output logic [REG_W-1:0]     bad_addr_o,
  output logic                 bus_req_o,
  output logic                 bus_we_o,
  output logic [31:0]          bus_addr_o,
  output logic [3:0]           bus_be_o,
  output logic [31:0]          bus_wdata_o,
  output logic                 stallreq_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_err;

  acc_size_t   w_size;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_mem;
  logic        w_misaligned;
  logic        w_access;
  logic [1:0]  w_lane;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  // Operation decode.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_size     = SZ_NONE;
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    unique case (aluop_i)
      EXE_LB_OP:              begin w_size = SZ_BYTE; w_is_load  = 1'b1; end
      EXE_LH_OP:              begin w_size = SZ_HALF; w_is_load  = 1'b1; end
      EXE_LW_OP, EXE_LWPC_OP: begin w_size = SZ_WORD; w_is_load  = 1'b1; end
      EXE_SB_OP:              begin w_size = SZ_BYTE; w_is_store = 1'b1; end
      EXE_SH_OP:              begin w_size = SZ_HALF; w_is_store = 1'b1; end
      EXE_SW_OP:              begin w_size = SZ_WORD; w_is_store = 1'b1; end
      default: ;
    endcase
  end

  assign w_is_mem = w_is_load | w_is_store;
  assign w_lane   = mem_addr_i[1:0];

  always_comb begin
    w_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_wdata      = reg2_i;
    unique case (w_size)
      SZ_BYTE: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{reg2_i[7:0]}};
      end
      SZ_HALF: begin
        w_misaligned = mem_addr_i[0];
        w_be         = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{reg2_i[15:0]}};
      end
      SZ_WORD: w_misaligned = (w_lane != 2'b00);
      default: ;
    endcase
  end

  // An upstream exception already kills this instruction: never touch the bus.
  assign w_access = w_is_mem & ~w_misaligned & (excepttype_i == 32'd0);

  // Lane extraction from the latched word; the address is still presented
  // during DONE because the pipeline is held until the end of that cycle.
  assign w_byte = r_rdata[{w_lane, 3'b000} +: 8];
  assign w_half = mem_addr_i[1] ? r_rdata[31:16] : r_rdata[15:0];

  always_comb begin
    unique case (w_size)
      SZ_BYTE: w_load_data = {{24{w_byte[7]}}, w_byte};
      SZ_HALF: w_load_data = {{16{w_half[15]}}, w_half};
      default: w_load_data = r_rdata;
    endcase
  end

  // Access sequencer. The counter counts stalled cycles including the issue
  // cycle, so a timeout releases the stall after exactly TIMEOUT cycles.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      // NOTE: the read-data latch is reset as well; it is a single register,
      // not a memory array, and clearing it keeps the outputs deterministic.
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_access) begin
            r_err <= 1'b0;
            if (bus_ack_i) begin
              r_rdata <= bus_rdata_i;
              r_state <= S_DONE;
            end else begin
              r_cnt   <= r_cnt + 8'd1;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus_ack_i) begin
            r_rdata <= bus_rdata_i;
            r_state <= S_DONE;
          end else if (r_cnt >= TIMEOUT_LAST) begin
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_cnt   <= 8'd0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output steering.
  always_comb begin
    wd_o         = wd_i;
    wreg_o       = wreg_i;
    wdata_o      = wdata_i;
    excepttype_o = excepttype_i;
    bad_addr_o   = 32'd0;
    bus_req_o    = 1'b0;
    stallreq_o   = 1'b0;
    bus_we_o     = w_is_store;
    bus_addr_o   = {mem_addr_i[31:2], 2'b00};
    bus_be_o     = w_be;
    bus_wdata_o  = w_wdata;

    if (w_is_mem) begin
      if (w_misaligned) begin
        excepttype_o[4] = w_is_load;
        excepttype_o[5] = w_is_store;
        bad_addr_o      = mem_addr_i;
        wreg_o          = 1'b0;
      end else if (excepttype_i != 32'd0) begin
        wreg_o = 1'b0;
      end else if (r_state == S_DONE) begin
        if (r_err) begin
          excepttype_o[6] = 1'b1;
          bad_addr_o      = mem_addr_i;
          wreg_o          = 1'b0;
        end else if (w_is_load) begin
          wdata_o = w_load_data;
        end
      end else begin
        // IDLE issue cycle and WAIT: hold the pipeline, write nothing back.
        bus_req_o  = 1'b1;
        stallreq_o = 1'b1;
        wreg_o     = 1'b0;
      end
    end

    if (rst) begin
      wd_o         = '0;
      wreg_o       = 1'b0;
      wdata_o      = 32'd0;
      excepttype_o = 32'd0;
      bad_addr_o   = 32'd0;
      bus_req_o    = 1'b0;
      stallreq_o   = 1'b0;
      bus_we_o     = 1'b0;
      bus_addr_o   = 32'd0;
      bus_be_o     = 4'd0;
      bus_wdata_o  = 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access
//
// Directed bench for mem_access (TIMEOUT=8). Each instruction is described at
// transaction level (op, address, data, cycle on which the slave acks). The
// expected per-cycle outputs are derived from the access rules with plain
// arithmetic and compared every cycle at the falling edge. Literal
// expectations for key scenarios pin the model itself.
// -----------------------------------------------------------------------------
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i, excepttype_i, bus_rdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i, bus_ack_i;

  logic [4:0]  wd_o;
  logic        wreg_o, bus_req_o, bus_we_o, stallreq_o;
  logic [31:0] wdata_o, excepttype_o, bad_addr_o, bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
    .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .excepttype_i(excepttype_i), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .excepttype_o(excepttype_o), .bad_addr_o(bad_addr_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .stallreq_o(stallreq_o)
  );

  int checks = 0;
  int failures = 0;
  int stall_total = 0;

  // Expectations for the current cycle.
  logic        exp_zero, exp_bus_v, exp_out_v, exp_req, exp_stall, exp_we;
  logic [31:0] exp_addr, exp_bw, exp_wdata, exp_exc, exp_bad;
  logic [3:0]  exp_be;
  logic [4:0]  exp_wd;
  logic        exp_wreg;

  // Snapshots of the last sampled cycle, the first stall cycle and the
  // result cycle of the most recent instruction.
  logic        snap_stall, snap_req, snap_we, snap_wreg;
  logic [3:0]  snap_be;
  logic [31:0] snap_bw, snap_wdata, snap_exc, snap_bad;
  logic        first_we;
  logic [3:0]  first_be;
  logic [31:0] first_bw;
  logic        done_stall, done_req, done_wreg;
  logic [31:0] done_wdata, done_exc, done_bad;
  int          op_stalls;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // One clock cycle: compare at the falling edge, then move past the next
  // rising edge so stimulus changes never coincide with it.
  task automatic step();
    @(negedge clk);
    if (exp_zero) begin
      check("rst_wd",    32'(wd_o), 32'd0);
      check("rst_wreg",  32'(wreg_o), 32'd0);
      check("rst_wdata", wdata_o, 32'd0);
      check("rst_exc",   excepttype_o, 32'd0);
      check("rst_bad",   bad_addr_o, 32'd0);
      check("rst_req",   32'(bus_req_o), 32'd0);
      check("rst_stall", 32'(stallreq_o), 32'd0);
      check("rst_we",    32'(bus_we_o), 32'd0);
      check("rst_baddr", bus_addr_o, 32'd0);
      check("rst_be",    32'(bus_be_o), 32'd0);
      check("rst_bw",    bus_wdata_o, 32'd0);
    end else begin
      check("req",   32'(bus_req_o), 32'(exp_req));
      check("stall", 32'(stallreq_o), 32'(exp_stall));
      if (exp_bus_v) begin
        check("bus_we",    32'(bus_we_o), 32'(exp_we));
        check("bus_addr",  bus_addr_o, exp_addr);
        check("bus_be",    32'(bus_be_o), 32'(exp_be));
        check("bus_wdata", bus_wdata_o, exp_bw);
      end
      if (exp_out_v) begin
        check("wd",    32'(wd_o), 32'(exp_wd));
        check("wreg",  32'(wreg_o), 32'(exp_wreg));
        check("wdata", wdata_o, exp_wdata);
        check("exc",   excepttype_o, exp_exc);
        check("bad",   bad_addr_o, exp_bad);
      end
    end
    if (stallreq_o === 1'b1) stall_total++;
    snap_stall = stallreq_o;  snap_req  = bus_req_o;   snap_we    = bus_we_o;
    snap_be    = bus_be_o;    snap_bw   = bus_wdata_o; snap_wreg  = wreg_o;
    snap_wdata = wdata_o;     snap_exc  = excepttype_o; snap_bad  = bad_addr_o;
    @(posedge clk);
    #1;
  endtask

  // ---- Reference rules -------------------------------------------------------
  function automatic int op_size(input logic [7:0] op);
    if (op == EXE_LB_OP || op == EXE_SB_OP) return 1;
    if (op == EXE_LH_OP || op == EXE_SH_OP) return 2;
    if (op == EXE_LW_OP || op == EXE_LWPC_OP || op == EXE_SW_OP) return 4;
    return 0;
  endfunction

  function automatic bit op_is_load(input logic [7:0] op);
    return op == EXE_LB_OP || op == EXE_LH_OP || op == EXE_LW_OP ||
           op == EXE_LWPC_OP;
  endfunction

  function automatic logic [3:0] lanes(input int size, input logic [31:0] addr);
    int unsigned ofs = addr % 4;
    if (size == 1) return 4'(1 << ofs);
    if (size == 2) return (ofs >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] store_word(input int size, input logic [31:0] d);
    if (size == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (size == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] load_value(input int size, input logic [31:0] addr,
                                             input logic [31:0] w);
    logic [31:0] v;
    if (size == 1) begin
      v = (w >> (8 * (addr % 4))) & 32'hFF;
      if (v >= 32'd128) v = v | 32'hFFFF_FF00;
      return v;
    end
    if (size == 2) begin
      v = (w >> (((addr % 4) >= 2) ? 16 : 0)) & 32'hFFFF;
      if (v >= 32'h8000) v = v | 32'hFFFF_0000;
      return v;
    end
    return w;
  endfunction

  // Present one instruction; the slave acks on stall cycle ack_at (0 = the
  // issue cycle) or never when ack_at < 0. For instructions that do not reach
  // the bus, ack_at == 0 drives a stray ack that must be ignored.
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic [31:0] wdat,
                        input logic [4:0] wd, input logic wr,
                        input logic [31:0] exc, input int ack_at,
                        input logic [31:0] rdata);
    int  size  = op_size(op);
    bit  load  = op_is_load(op);
    bit  align = (size == 0) || ((addr % size) == 0);
    bit  acked = (ack_at >= 0) && (ack_at < TO);
    int  n     = acked ? ack_at + 1 : TO;
    int  start = stall_total;
    aluop_i = op; mem_addr_i = addr; reg2_i = reg2; wdata_i = wdat;
    wd_i = wd; wreg_i = wr; excepttype_i = exc; bus_ack_i = 1'b0;
    exp_wd = wd;
    if (size == 0 || !align || exc != 32'd0) begin
      exp_bus_v = 1'b0; exp_out_v = 1'b1; exp_req = 1'b0; exp_stall = 1'b0;
      exp_wreg = (size == 0) ? wr : 1'b0;
      exp_wdata = wdat; exp_exc = exc; exp_bad = 32'd0;
      if (size != 0 && !align) begin
        exp_exc = exc | (load ? 32'h10 : 32'h20);
        exp_bad = addr;
      end
      bus_ack_i = (ack_at == 0); bus_rdata_i = rdata;
      step();
    end else begin
      exp_bus_v = 1'b1; exp_out_v = 1'b0; exp_req = 1'b1; exp_stall = 1'b1;
      exp_we = !load; exp_addr = addr & 32'hFFFF_FFFC;
      exp_be = lanes(size, addr); exp_bw = store_word(size, reg2);
      for (int k = 0; k < n; k++) begin
        bus_ack_i   = (k == ack_at);
        bus_rdata_i = (k == ack_at) ? rdata : (32'hBAD0_0000 | 32'(k));
        step();
        if (k == 0) begin first_we = snap_we; first_be = snap_be; first_bw = snap_bw; end
      end
      // Result cycle; a late ack here is ignored.
      bus_ack_i = 1'b1; bus_rdata_i = 32'h5555_AAAA;
      exp_bus_v = 1'b0; exp_out_v = 1'b1; exp_req = 1'b0; exp_stall = 1'b0;
      exp_wreg  = acked ? wr : 1'b0;
      exp_wdata = (load && acked) ? load_value(size, addr, rdata) : wdat;
      exp_exc   = acked ? exc : (exc | 32'h40);
      exp_bad   = acked ? 32'd0 : addr;
      step();
    end
    bus_ack_i  = 1'b0;
    op_stalls  = stall_total - start;
    done_stall = snap_stall; done_req = snap_req; done_wreg = snap_wreg;
    done_wdata = snap_wdata; done_exc = snap_exc; done_bad = snap_bad;
  endtask

  // ---- Directed sequence -----------------------------------------------------
  initial begin
    rst = 1'b1; exp_zero = 1'b1;
    exp_bus_v = 1'b0; exp_out_v = 1'b0; exp_req = 1'b0; exp_stall = 1'b0;
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h8000_0000; reg2_i = 32'h1;
    wdata_i = 32'h55; wd_i = 5'd3; wreg_i = 1'b1; excepttype_i = 32'd0;
    bus_rdata_i = 32'hFFFF_FFFF; bus_ack_i = 1'b1;
    step(); step();
    rst = 1'b0; exp_zero = 1'b0; bus_ack_i = 1'b0;

    // Pass-through with a stray ack.
    run_op(EXE_OR_OP, 32'h8000_0000, 32'h0, 32'h0000_1234, 5'd4, 1'b1, 32'd0, 0, 32'h0);
    check("or_wdata", done_wdata, 32'h0000_1234);
    check("or_stalls", 32'(op_stalls), 32'd0);

    run_op(EXE_LW_OP, 32'h8000_0004, 32'h0, 32'h0, 5'd5, 1'b1, 32'd0, 3, 32'hDEAD_BEEF);
    check("lw_stalls", 32'(op_stalls), 32'd4);
    check("lw_data",   done_wdata, 32'hDEAD_BEEF);
    check("lw_wreg",   32'(done_wreg), 32'd1);
    check("lw_be",     32'(first_be), 32'hF);

    run_op(EXE_LB_OP, 32'h8000_0003, 32'h0, 32'h0, 5'd6, 1'b1, 32'd0, 0, 32'h8011_2233);
    check("lb3_be",   32'(first_be), 32'h8);
    check("lb3_data", done_wdata, 32'hFFFF_FF80);
    check("lb3_stalls", 32'(op_stalls), 32'd1);

    run_op(EXE_LB_OP, 32'h8000_0001, 32'h0, 32'h0, 5'd6, 1'b1, 32'd0, 1, 32'h8011_2233);
    check("lb1_data", done_wdata, 32'h0000_0022);

    run_op(EXE_LH_OP, 32'h8000_0002, 32'h0, 32'h0, 5'd7, 1'b1, 32'd0, 2, 32'h8011_2233);
    check("lh2_data", done_wdata, 32'hFFFF_8011);

    run_op(EXE_SH_OP, 32'h8000_0002, 32'h0000_ABCD, 32'h77, 5'd0, 1'b0, 32'd0, 0, 32'h0);
    check("sh_we",    32'(first_we), 32'd1);
    check("sh_be",    32'(first_be), 32'hC);
    check("sh_wdata", first_bw, 32'hABCD_ABCD);
    check("sh_wreg",  32'(done_wreg), 32'd0);

    run_op(EXE_SB_OP, 32'h8000_0001, 32'h1234_565A, 32'h0, 5'd0, 1'b0, 32'd0, 1, 32'h0);
    check("sb_wdata", first_bw, 32'h5A5A_5A5A);

    run_op(EXE_LW_OP, 32'h8000_0002, 32'h0, 32'h0, 5'd8, 1'b1, 32'd0, 0, 32'h0);
    check("lw_mis_req", 32'(done_req), 32'd0);
    check("lw_mis_stall", 32'(done_stall), 32'd0);
    check("lw_mis_exc", done_exc, 32'h10);
    check("lw_mis_bad", done_bad, 32'h8000_0002);

    run_op(EXE_SW_OP, 32'h8000_0002, 32'h1, 32'h0, 5'd0, 1'b0, 32'd0, -1, 32'h0);
    check("sw_mis_exc", done_exc, 32'h20);

    run_op(EXE_SH_OP, 32'h8000_0001, 32'h1, 32'h0, 5'd0, 1'b0, 32'd0, -1, 32'h0);
    run_op(EXE_LW_OP, 32'h8000_0008, 32'h0, 32'h0, 5'd9, 1'b1, 32'h0000_0008, -1, 32'h0);
    check("exc_in_stalls", 32'(op_stalls), 32'd0);

    run_op(EXE_LW_OP, 32'h8000_000C, 32'h0, 32'h0, 5'd10, 1'b1, 32'd0, -1, 32'h0);
    check("to_stalls", 32'(op_stalls), 32'd8);
    check("to_exc",    done_exc, 32'h40);
    check("to_wreg",   32'(done_wreg), 32'd0);
    check("to_bad",    done_bad, 32'h8000_000C);

    // Ack on the very last allowed cycle still completes normally.
    run_op(EXE_LWPC_OP, 32'h8000_0010, 32'h0, 32'h0, 5'd11, 1'b1, 32'd0, TO - 1, 32'h0102_0304);
    check("lwpc_data", done_wdata, 32'h0102_0304);
    check("lwpc_stalls", 32'(op_stalls), 32'd8);

    // Reset while waiting for the bus, then a plain ALU op.
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h8000_0008; wd_i = 5'd12; wreg_i = 1'b1;
    excepttype_i = 32'd0; bus_ack_i = 1'b0;
    exp_bus_v = 1'b1; exp_out_v = 1'b0; exp_req = 1'b1; exp_stall = 1'b1;
    exp_we = 1'b0; exp_addr = 32'h8000_0008; exp_be = 4'hF; exp_bw = reg2_i;
    step(); step();
    rst = 1'b1; exp_zero = 1'b1;
    step();
    rst = 1'b0; exp_zero = 1'b0;
    run_op(EXE_OR_OP, 32'h8000_0008, 32'h0, 32'h0000_0012, 5'd13, 1'b1, 32'd0, -1, 32'h0);
    check("rst_or_req",   32'(done_req), 32'd0);
    check("rst_or_wdata", done_wdata, 32'h0000_0012);
    check("rst_or_stalls", 32'(op_stalls), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the 5-stage MIPS pipeline; consumes the EX/MEM pipeline register outputs (aluop, mem_addr, reg2, wd/wreg/wdata, excepttype).
- Performs loads/stores over a single-outstanding req/ack data bus.
- Stalls the pipeline until the access completes, extends load data, and flags misaligned addresses and bus timeouts as exceptions.
- Non-memory instructions pass through in zero added latency.

Parameters:
- TIMEOUT, 255, cycles to wait for bus_ack_i before aborting with a bus-error exception (8-bit counter).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous reset, active-high; acts on the rising edge of clk
- aluop_i  in  `AluOpBus  operation from EX/MEM register
- mem_addr_i  in  `RegBus  effective address
- reg2_i  in  `RegBus  store data
- wd_i  in  `RegAddrBus  destination register
- wreg_i  in  1  register write enable
- wdata_i  in  `RegBus  EX result for non-load ops
- excepttype_i  in  32  exception vector from EX
- bus_rdata_i  in  32  read data
- bus_ack_i  in  1  access complete, one-cycle pulse
- wd_o  out  `RegAddrBus  to MEM/WB
- wreg_o  out  1  to MEM/WB
- wdata_o  out  `RegBus  to MEM/WB
- excepttype_o  out  32  exception vector to CP0 logic
- bad_addr_o  out  `RegBus  faulting address (BadVAddr)
- bus_req_o  out  1  access request
- bus_we_o  out  1  1 = store
- bus_addr_o  out  32  word-aligned address, {mem_addr_i[31:2],2'b00}
- bus_be_o  out  4  byte enables, little-endian lanes
- bus_wdata_o  out  32  lane-replicated store data
- stallreq_o  out  1  stall request to the ctrl block

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; timeout counter=0; data latch=0; bus_req_o=0.
  - While rst=1, all combinational outputs are forced to 0.
- Memory op = LB, LH, LW, LWPC, SB, SH, SW. All other ops:
  - wd_o/wreg_o/wdata_o = inputs.
  - excepttype_o = excepttype_i.
  - bus_req_o=0, stallreq_o=0.
- Alignment check (combinational):
  - LH/SH require addr[0]=0.
  - LW/LWPC/SW require addr[1:0]=0.
  - Misaligned load: set excepttype_o[4] (AdEL). Misaligned store: set excepttype_o[5] (AdES).
  - On misalignment: bad_addr_o=mem_addr_i, wreg_o=0, no bus access.
- Exception suppression: if excepttype_i != 0, no bus access and wreg_o=0.
- Byte enables:
  - SB/LB: 1<<addr[1:0].
  - SH/LH: addr[1]?4'b1100:4'b0011.
  - Word: 4'b1111.
- Store data:
  - SB: {4{reg2_i[7:0]}}.
  - SH: {2{reg2_i[15:0]}}.
  - SW: reg2_i.
- FSM:
  - IDLE
    - Valid aligned mem op: bus_req_o=1 combinationally and stallreq_o=1.
    - If bus_ack_i is also 1 this cycle, latch rdata and go to DONE; else go to WAIT.
  - WAIT
    - bus_req_o=1 and stallreq_o=1; address, we, be and wdata held stable from the stalled inputs.
    - Counter increments each cycle.
    - On bus_ack_i: latch bus_rdata_i, go to DONE.
    - On counter==TIMEOUT-1 without ack: go to DONE with err flag set.
  - DONE
    - bus_req_o=0, stallreq_o=0; the result is presented; counter clears.
    - Unconditionally return to IDLE next cycle.
    - The pipeline advances at the end of DONE, which prevents re-issuing the same instruction.
- Load result in DONE, taken from the latched word at lane addr[1:0]:
  - LB: sign-extended byte.
  - LH: sign-extended half.
  - LW/LWPC: full word.
  - Stores in DONE: wdata_o=wdata_i.
- Bus error: err in DONE sets excepttype_o[6], sets bad_addr_o=mem_addr_i, forces wreg_o=0.
- bus_ack_i is ignored in IDLE without a request and in DONE.
- Reset mid-access: abandon the transaction, return to IDLE. The bus slave must tolerate req dropping.
- Minimum memory-op latency is 1 stall cycle (ack in the same cycle) + the DONE cycle.

Test Plan:
- LW addr 0x80000004, ack after 3 cycles with rdata 0xDEADBEEF -> stallreq_o high for 4 cycles; DONE wdata_o=0xDEADBEEF, wreg_o=1, bus_be_o=4'hF during request.
- LB addr 0x80000003, rdata 0x80112233 -> bus_be_o=4'b1000, wdata_o=0xFFFFFF80; LB addr ...1 -> 0x00000022.
- SH addr 0x80000002, reg2 0x0000ABCD -> bus_we_o=1, bus_be_o=4'b1100, bus_wdata_o=0xABCDABCD, wreg_o=0.
- LW addr 0x80000002 -> no bus_req_o, stallreq_o=0, excepttype_o[4]=1, bad_addr_o=0x80000002; SW same addr -> excepttype_o[5]=1.
- LW with no ack (TIMEOUT=8) -> stallreq_o high exactly 8 cycles, then excepttype_o[6]=1, wreg_o=0, FSM back to IDLE.
- rst asserted in WAIT -> next cycle bus_req_o=0, state IDLE; OR op with wdata_i 0x12 afterwards passes through unchanged with no stall.
